pipe_stage_fifo: RTL and testbench
==================================

Name: pipe_stage_fifo

Overview:
- Parametrised successor to the fixed CPU stage registers: one generic pipeline stage holding up to DEPTH entries, with valid/ready handshake on both sides.
- Each entry carries a data payload and a control field. On flush, the control field is zeroed, so downstream sees bubbles.
- Replaces per-stage stall/flush registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and absorbs short memory-wait stalls without back-propagating them combinationally.

Parameters:
- DATA_W, 64, payload width in bits (pc, alu result, store data, addresses packed by the instantiating stage).
- CTRL_W, 8, control-bit width (reg_w, mem_r, mem_w, wb_sel, ...); forced to 0 on flush and when out_valid=0.
- DEPTH, 2, number of entries; power of 2, range 1..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous discard of all held entries and of this cycle's input.
- in_valid  input  1  upstream has an entry.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  DATA_W  upstream payload.
- in_ctrl  input  CTRL_W  upstream control bits.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  downstream accepts the head entry.
- out_data  output  DATA_W  head payload.
- out_ctrl  output  CTRL_W  head control bits.
- count  output  $clog2(DEPTH+1)  number of held entries.
- stall_cnt  output  16  perf: cycles with out_valid=1 and out_ready=0 (see Optional Feature).
- drop_cnt  output  16  perf: entries discarded by flush (see Optional Feature).

Behaviour:
- Reset (async, rst=1): count=0, read/write pointers=0, all entry ctrl=0, out_valid=0, out_data=0, out_ctrl=0, in_ready=1, stall_cnt=0, drop_cnt=0.
- Storage: circular buffer of DEPTH entries; rd_ptr and wr_ptr wrap modulo DEPTH; count is registered.
- in_ready = (count < DEPTH), decoded from registered count only; it has no combinational path from out_ready.
- No pass-through when full: with count==DEPTH and out_ready=1, in_ready is still 0 that cycle.
- Handshakes:
  - push = in_valid & in_ready & ~flush
  - pop = out_valid & out_ready & ~flush
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged; the write goes to wr_ptr and the head advances.
- Latency: an entry pushed in cycle N appears at out_* in cycle N+1 at the earliest, when the buffer was empty.
- Output: out_valid = (count != 0). out_data and out_ctrl equal the entry at rd_ptr when out_valid=1, and 0 when out_valid=0.
- Flush (sync, highest priority over push/pop): next count=0, pointers=0, all entry ctrl cleared, and the in_* entry of that cycle is dropped. in_ready is still driven from count during the flush cycle, but no push occurs.
- Simultaneous rst and flush: rst wins (async).
- rst asserted mid-transfer: all state is cleared immediately; in-flight entries are lost without being counted.
- Upstream rule: in_data and in_ctrl must be held while in_valid=1 and in_ready=0. The stage itself never drops an accepted entry except on flush.
- DEPTH=1 degenerates to a single-entry stage register; throughput is then 1 entry per 2 cycles under continuous flow.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt increments every cycle with out_valid=1, out_ready=0, flush=0.
  - drop_cnt adds count on every flush cycle, plus 1 if in_valid=1 that cycle.
  - Both saturate at 16'hFFFF and clear only on rst.
- Not defined: stall_cnt and drop_cnt are tied to 16'd0, with no counter flops; the port list is unchanged.

Test Plan:
- Reset, then in_valid=1, in_data=64'h1234, in_ctrl=8'h5A, out_ready=1 for one cycle -> next cycle out_valid=1, out_data=64'h1234, out_ctrl=8'h5A, count=1; the cycle after, count=0 and out_data=0.
- DEPTH=2: hold out_ready=0 and push A, B, C -> A and B accepted, in_ready=0 with count=2, C held upstream. Raise out_ready -> A, B, C emerge in order, no loss or duplication.
- Continuous in_valid=1, out_ready=1 with 100 incrementing values -> one output per cycle after 1-cycle latency, values in order, count stays 1.
- count=2 with in_valid=1, then flush=1 for one cycle -> next cycle count=0, out_valid=0, out_ctrl=0. With PIPE_STAGE_PERF_EN, drop_cnt=3.
- With PIPE_STAGE_PERF_EN: out_valid=1 and out_ready=0 for 70000 cycles -> stall_cnt saturates at 16'hFFFF. Without the macro, stall_cnt=0 throughout.
- Assert rst mid-stream with count=2 -> out_valid, out_data and count go to 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/pipe_stage_fifo_if.sv
// Valid/ready handshake bundle for pipe_stage_fifo: upstream (in_*) and downstream (out_*) sides.
interface pipe_stage_fifo_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport master (
    output in_valid, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_data, out_ctrl
  );

  modport slave (
    input  in_valid, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_data, out_ctrl
  );
endinterface

// File: rtl/pipe_stage_fifo.sv
// Generic pipeline stage: DEPTH-entry circular buffer with valid/ready on both sides and flush.
// Define PIPE_STAGE_PERF_EN to enable the saturating stall/drop performance counters.
module pipe_stage_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_fifo_if.slave bus,
  output logic [CNT_W-1:0] count,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic              push;
  logic              pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Handshake decode works from registered count only, so no out_ready -> in_ready path exists.
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? data_q[rd_ptr] : '0;
  assign bus.out_ctrl  = bus.out_valid ? ctrl_q[rd_ptr] : '0;

  assign push = bus.in_valid  & bus.in_ready  & ~flush;
  assign pop  = bus.out_valid & bus.out_ready & ~flush;

  // Buffer storage, pointers and occupancy; flush overrides any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        ctrl_q[i] <= '0;
      end
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      if (push) begin
        data_q[wr_ptr] <= bus.in_data;
        ctrl_q[wr_ptr] <= bus.in_ctrl;
        wr_ptr         <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [16:0] drop_sum;

  assign drop_sum = 17'(drop_cnt) + 17'(count) + 17'(bus.in_valid);

  // Saturating perf counters, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && !flush && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (flush) begin
        drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
    end
  end
`else
  assign stall_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Self-checking bench for pipe_stage_fifo: queue-based reference model plus directed and random traffic.
module tb_pipe_stage_fifo;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned DEPTH  = 2;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } entry_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic [15:0]      stall_cnt;
  logic [15:0]      drop_cnt;

  pipe_stage_fifo_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

  pipe_stage_fifo #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .count     (count),
    .stall_cnt (stall_cnt),
    .drop_cnt  (drop_cnt)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  entry_t q[$];
  int     m_stall = 0;
  int     m_drop  = 0;
  bit     chk_en  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue updated by the handshake rules at each rising edge.
  always @(posedge clk) begin
    int n;
    bit p;
    bit o;
    if (!rst) begin
      n = q.size();
      p = bus.in_valid && (n < int'(DEPTH)) && !flush;
      o = (n != 0) && bus.out_ready && !flush;
`ifdef PIPE_STAGE_PERF_EN
      if (n != 0 && !bus.out_ready && !flush && m_stall < 65535) m_stall++;
      if (flush) begin
        m_drop = m_drop + n + int'(bus.in_valid);
        if (m_drop > 65535) m_drop = 65535;
      end
`endif
      if (flush) q.delete();
      else begin
        if (o) void'(q.pop_front());
        if (p) q.push_back('{bus.in_data, bus.in_ctrl});
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("count", 64'(count), 64'(q.size()));
      chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      chk("in_ready", 64'(bus.in_ready), 64'(q.size() < int'(DEPTH)));
      chk("out_data", bus.out_data, (q.size() != 0) ? q[0].d : 64'h0);
      chk("out_ctrl", 64'(bus.out_ctrl), (q.size() != 0) ? 64'(q[0].c) : 64'h0);
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  task automatic drive(input bit iv, input logic [63:0] d, input logic [7:0] c,
                       input bit ordy, input bit fl);
    @(negedge clk);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_ctrl   = c;
    bus.out_ready = ordy;
    flush         = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    q.delete();
    m_stall = 0;
    m_drop  = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] d;
    logic [7:0]  c;
    bit          fl;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_ctrl = '0;
    bus.out_ready = 1'b0;
    #12;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'h1);
    chk("rst_out_data", bus.out_data, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Single entry, one-cycle latency.
    drive(1, 64'h1234, 8'h5A, 1, 0);
    chk("t1_out_valid", 64'(bus.out_valid), 64'h1);
    chk("t1_out_data", bus.out_data, 64'h1234);
    chk("t1_out_ctrl", 64'(bus.out_ctrl), 64'h5A);
    chk("t1_count", 64'(count), 64'h1);
    drive(0, 64'h0, 8'h0, 1, 0);
    chk("t1_count_after", 64'(count), 64'h0);
    chk("t1_out_data_after", bus.out_data, 64'h0);

    // Back-pressure: A, B accepted, C held until space frees up.
    drive(1, 64'hA, 8'h01, 0, 0);
    drive(1, 64'hB, 8'h02, 0, 0);
    drive(1, 64'hC, 8'h03, 0, 0);
    chk("t2_full_count", 64'(count), 64'h2);
    chk("t2_full_in_ready", 64'(bus.in_ready), 64'h0);
    chk("t2_head_a", bus.out_data, 64'hA);
    drive(1, 64'hC, 8'h03, 1, 0);
    chk("t2_head_b", bus.out_data, 64'hB);
    chk("t2_count_1", 64'(count), 64'h1);
    drive(1, 64'hC, 8'h03, 1, 0);
    chk("t2_head_c", bus.out_data, 64'hC);
    chk("t2_ctrl_c", 64'(bus.out_ctrl), 64'h03);
    drive(0, 64'h0, 8'h0, 1, 0);
    chk("t2_drained", 64'(count), 64'h0);

    // Continuous streaming at full throughput.
    for (int i = 0; i < 100; i++) begin
      drive(1, 64'(i + 100), 8'(i), 1, 0);
      chk("t3_count", 64'(count), 64'h1);
      chk("t3_data", bus.out_data, 64'(i + 100));
    end
    drive(0, 64'h0, 8'h0, 1, 0);

    // Flush with a full buffer and a pending input.
    do_reset();
    drive(1, 64'h11, 8'hF1, 0, 0);
    drive(1, 64'h22, 8'hF2, 0, 0);
    drive(1, 64'h33, 8'hF3, 0, 1);
    chk("t4_count", 64'(count), 64'h0);
    chk("t4_out_valid", 64'(bus.out_valid), 64'h0);
    chk("t4_out_ctrl", 64'(bus.out_ctrl), 64'h0);
`ifdef PIPE_STAGE_PERF_EN
    chk("t4_drop_cnt", 64'(drop_cnt), 64'h3);
`else
    chk("t4_drop_cnt", 64'(drop_cnt), 64'h0);
`endif
    drive(0, 64'h0, 8'h0, 1, 0);

    // Random traffic with occasional flushes; upstream holds a stalled entry.
    for (int i = 0; i < 3000; i++) begin
      if (bus.in_valid && !bus.in_ready && !flush) begin
        d = bus.in_data;
        c = bus.in_ctrl;
        fl = ($urandom_range(0, 31) == 0);
        drive(1, d, c, 1'($urandom_range(0, 1)), fl);
      end else begin
        d = {$urandom, $urandom};
        c = 8'($urandom);
        fl = ($urandom_range(0, 31) == 0);
        drive(1'($urandom_range(0, 2) != 0), d, c, 1'($urandom_range(0, 1)), fl);
      end
    end
    drive(0, 64'h0, 8'h0, 1, 0);
    drive(0, 64'h0, 8'h0, 1, 0);

    // Long stall: saturates when perf counters are built, stays 0 otherwise.
    do_reset();
    drive(1, 64'h77, 8'h07, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
    for (int i = 0; i < 70000; i++) drive(0, 64'h0, 8'h0, 0, 0);
    chk("t5_stall_sat", 64'(stall_cnt), 64'hFFFF);
`else
    for (int i = 0; i < 200; i++) drive(0, 64'h0, 8'h0, 0, 0);
    chk("t5_stall_off", 64'(stall_cnt), 64'h0);
`endif

    // Asynchronous reset mid-stream.
    drive(1, 64'h88, 8'h08, 0, 0);
    chk("t6_pre_count", 64'(count), 64'h2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    m_stall = 0;
    m_drop  = 0;
    #1;
    chk("t6_count", 64'(count), 64'h0);
    chk("t6_out_valid", 64'(bus.out_valid), 64'h0);
    chk("t6_out_data", bus.out_data, 64'h0);
    chk("t6_stall_cnt", 64'(stall_cnt), 64'h0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive(1, 64'h99, 8'h09, 1, 0);
    chk("t6_after_data", bus.out_data, 64'h99);
    drive(0, 64'h0, 8'h0, 1, 0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
